// File: rtl/adder_pkg.sv
// Shared types and default sizing for the chunked ripple-carry adder.
package adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 64;
  localparam int unsigned DEFAULT_CHUNK = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rca_chunk.sv
// Combinational W-bit ripple-carry adder built from full-adder cells.
module rca_chunk #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co
);

  logic [W:0] cy;

  assign cy[0] = ci;

  for (genvar i = 0; i < int'(W); i++) begin : g_fa
    assign sum[i]  = x[i] ^ y[i] ^ cy[i];
    assign cy[i+1] = (x[i] & y[i]) | (cy[i] & (x[i] ^ y[i]));
  end

  assign co = cy[W];

endmodule

// File: rtl/pipe_rca_adder.sv
// Multi-cycle adder: one CHUNK-bit ripple-carry slice reused over WIDTH/CHUNK cycles.
// Define PIPE_RCA_OVF_EN to add the registered signed-overflow output ovf.
module pipe_rca_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c
`ifdef PIPE_RCA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NUM_CHUNKS = WIDTH / CHUNK;
  localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("pipe_rca_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t             state_q, state_d;
  logic               in_ready_d, out_valid_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               cy_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CHUNK-1:0]   x_sel, y_sel, sum;
  logic               co;

  // State and handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Flags follow the upcoming state so they are valid straight out of a flop
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    if (state_d == IDLE) in_ready_d  = 1'b1;
    if (state_d == DONE) out_valid_d = 1'b1;
  end

  always_comb begin
    x_sel = '0;
    y_sel = '0;
    for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        x_sel = a_q[i*CHUNK +: CHUNK];
        y_sel = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  rca_chunk #(
    .W (CHUNK)
  ) u_rca (
    .x   (x_sel),
    .y   (y_sel),
    .ci  (cy_q),
    .sum (sum),
    .co  (co)
  );

  // Operand capture and chunk-by-chunk result write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cy_q  <= 1'b0;
      idx_q <= '0;
      s     <= '0;
      c     <= 1'b0;
`ifdef PIPE_RCA_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (state_q == IDLE) begin
      if (in_valid) begin
        a_q   <= a;
        b_q   <= b;
        cy_q  <= c0;
        idx_q <= '0;
      end
    end else if (state_q == BUSY) begin
      for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
        if (idx_q == IDX_W'(i)) s[i*CHUNK +: CHUNK] <= sum;
      end
      cy_q  <= co;
      idx_q <= idx_q + IDX_W'(1);
      if (idx_q == LAST_IDX) begin
        c   <= co;
`ifdef PIPE_RCA_OVF_EN
        ovf <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[CHUNK-1] != a_q[WIDTH-1]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_pipe_rca_adder.sv
// Randomized self-checking bench for pipe_rca_adder (CHUNK=16 and CHUNK=64 instances).
module tb_pipe_rca_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] a, b;
  logic        c0;
  logic        iv0, ir0, ov0, or0, cc0;
  logic        iv1, ir1, ov1, or1, cc1;
  logic [63:0] s0, s1;
`ifdef PIPE_RCA_OVF_EN
  logic        ovf0, ovf1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_rca_adder #(.WIDTH(64), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b), .c0(c0),
    .out_valid(ov0), .out_ready(or0), .s(s0), .c(cc0)
`ifdef PIPE_RCA_OVF_EN
    , .ovf(ovf0)
`endif
  );

  pipe_rca_adder #(.WIDTH(64), .CHUNK(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b), .c0(c0),
    .out_valid(ov1), .out_ready(or1), .s(s1), .c(cc1)
`ifdef PIPE_RCA_OVF_EN
    , .ovf(ovf1)
`endif
  );

  function automatic logic get_ir(input int w);
    return (w == 0) ? ir0 : ir1;
  endfunction
  function automatic logic get_ov(input int w);
    return (w == 0) ? ov0 : ov1;
  endfunction
  function automatic logic [63:0] get_s(input int w);
    return (w == 0) ? s0 : s1;
  endfunction
  function automatic logic get_c(input int w);
    return (w == 0) ? cc0 : cc1;
  endfunction
  function automatic logic get_ovf(input int w);
`ifdef PIPE_RCA_OVF_EN
    return (w == 0) ? ovf0 : ovf1;
`else
    return (w < 0);
`endif
  endfunction

  // Reference model: plain 65-bit arithmetic, signed range test for overflow
  function automatic logic [64:0] model_sum(input logic [63:0] x, input logic [63:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + 65'(ci);
  endfunction
  function automatic logic model_ovf(input logic [63:0] x, input logic [63:0] y, input logic ci);
    logic signed [64:0] t;
    t = $signed({x[63], x}) + $signed({y[63], y}) + $signed({64'd0, ci});
    return t[64] != t[63];
  endfunction
  function automatic int model_lat(input int w);
    return (w == 0) ? 64 / 16 : 64 / 64;
  endfunction

  task automatic set_iv(input int w, input logic v);
    if (w == 0) iv0 = v; else iv1 = v;
  endtask
  task automatic set_or(input int w, input logic v);
    if (w == 0) or0 = v; else or1 = v;
  endtask

  // Offer operands, then count cycles from the accept edge to out_valid (-1 on timeout)
  task automatic start_op(input int w, input logic [63:0] ta, input logic [63:0] tb,
                          input logic tc, output int lat);
    int n;
    n = 0;
    while (!get_ir(w) && n < 50) begin @(posedge clk); #1; n++; end
    a = ta; b = tb; c0 = tc;
    set_iv(w, 1'b1);
    @(posedge clk); #1;
    set_iv(w, 1'b0);
    n = 0;
    while (!get_ov(w) && n < 50) begin @(posedge clk); #1; n++; end
    lat = get_ov(w) ? n : -1;
  endtask

  task automatic release_op(input int w);
    set_or(w, 1'b1);
    @(posedge clk); #1;
    set_or(w, 1'b0);
  endtask

  task automatic check_op(input string name, input int w, input logic [63:0] ta,
                          input logic [63:0] tb, input logic tc);
    int lat;
    logic [64:0] m;
    m = model_sum(ta, tb, tc);
    start_op(w, ta, tb, tc, lat);
    n_tests++;
    if (lat !== model_lat(w)) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, model_lat(w));
    end
    n_tests++;
    if (get_s(w) !== m[63:0] || get_c(w) !== m[64]) begin
      n_fail++;
      $display("FAIL %s result: got s=%h c=%b, expected s=%h c=%b", name, get_s(w), get_c(w), m[63:0], m[64]);
    end
`ifdef PIPE_RCA_OVF_EN
    n_tests++;
    if (get_ovf(w) !== model_ovf(ta, tb, tc)) begin
      n_fail++;
      $display("FAIL %s ovf: got %b, expected %b", name, get_ovf(w), model_ovf(ta, tb, tc));
    end
`endif
    release_op(w);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      n_tests++;
      if (get_ir(w) !== 1'b1 || get_ov(w) !== 1'b0 || get_s(w) !== 64'd0 ||
          get_c(w) !== 1'b0 || get_ovf(w) === 1'b1) begin
        n_fail++;
        $display("FAIL reset[%0d]: got in_ready=%b out_valid=%b s=%h c=%b, expected 1 0 0 0",
                 w, get_ir(w), get_ov(w), get_s(w), get_c(w));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    check_op("pattern16", 0, 64'h02EB02EB02EB02EB, 64'h555502EB02EB02EB, 1'b0);
    check_op("carry_chain16", 0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1);
    check_op("ovf_pos16", 0, 64'h7FFFFFFFFFFFFFFF, 64'd1, 1'b0);
    check_op("pattern64", 1, 64'h02EB02EB02EB02EB, 64'h555502EB02EB02EB, 1'b0);
    check_op("carry_chain64", 1, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1);
    check_op("ovf_neg16", 0, 64'h8000000000000000, 64'h8000000000000000, 1'b0);
  endtask

  task automatic test_random;
    logic [63:0] ra, rb;
    for (int i = 0; i < 24; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 6 == 0) rb = ~ra;
      check_op("random", i % 2, ra, rb, 1'($urandom_range(0, 1)));
    end
  endtask

  // Result must hold while the consumer stalls; new operands are ignored
  task automatic test_stall;
    int lat;
    logic [64:0] m;
    m = model_sum(64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 1'b1);
    start_op(0, 64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 1'b1, lat);
    a = 64'hDEADBEEFDEADBEEF; b = 64'h1111111111111111; c0 = 1'b0;
    iv0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (s0 !== m[63:0] || cc0 !== m[64] || ir0 !== 1'b0 || ov0 !== 1'b1) begin
        n_fail++;
        $display("FAIL stall cycle %0d: got s=%h c=%b in_ready=%b out_valid=%b, expected s=%h c=%b 0 1",
                 i, s0, cc0, ir0, ov0, m[63:0], m[64]);
      end
      @(posedge clk); #1;
    end
    release_op(0);
    n_tests++;
    if (ir0 !== 1'b1 || ov0 !== 1'b0 || s0 !== m[63:0] || cc0 !== m[64]) begin
      n_fail++;
      $display("FAIL stall_release: got in_ready=%b out_valid=%b s=%h c=%b, expected 1 0 s=%h c=%b",
               ir0, ov0, s0, cc0, m[63:0], m[64]);
    end
    iv0 = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (ir0 !== 1'b1 || ov0 !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_no_capture: got in_ready=%b out_valid=%b, expected 1 0", ir0, ov0);
    end
  endtask

  task automatic test_reset_abort;
    int seen;
    a = 64'hFFFF0000FFFF0000; b = 64'h0001FFFF0001FFFF; c0 = 1'b1;
    iv0 = 1'b1;
    @(posedge clk); #1;
    iv0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if (ir0 !== 1'b1 || ov0 !== 1'b0 || s0 !== 64'd0 || cc0 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: got in_ready=%b out_valid=%b s=%h c=%b, expected 1 0 0 0", ir0, ov0, s0, cc0);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (ov0) seen++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_result: got out_valid high %0d cycles, expected 0", seen);
    end
    check_op("after_abort", 0, 64'hFFFF0000FFFF0000, 64'h0001FFFF0001FFFF, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    iv0 = 1'b0; or0 = 1'b0; iv1 = 1'b0; or1 = 1'b0;
    a = '0; b = '0; c0 = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
